// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 control sequencer: state encoding,
// datapath mux/ALU codes, opcode values and the per-state control decode.
package slc3_pkg;

    typedef enum logic [3:0] {
        S_HALTED = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_FETCH3 = 4'd3,
        S_DECODE = 4'd4,
        S_BR0    = 4'd5,
        S_BR1    = 4'd6,
        S_ADD0   = 4'd7,
        S_AND0   = 4'd8,
        S_NOT0   = 4'd9,
        S_LDR0   = 4'd10,
        S_LDR1   = 4'd11,
        S_LDR2   = 4'd12,
        S_PAUSE0 = 4'd13,
        S_PAUSE1 = 4'd14
    } state_t;

    // ALU function select
    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    // PC source select
    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    // Address adder operand selects
    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;
    localparam logic       ADDR1_PC    = 1'b0;
    localparam logic       ADDR1_BASER = 1'b1;

    // Opcodes handled by this sequencer (IR[15:12])
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    // Control word driven to the datapath; sr2_en gates IR_5 onto SR2MUX
    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic       addr1mux;
        logic       sr2_en;
        logic [1:0] aluk;
        logic       mem_oe;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: '0};

    // Moore output table: control word for a given state
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = CTRL_NONE;
        case (s)
            S_FETCH1: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.ld_pc   = 1'b1;
                c.pcmux   = PCMUX_INC;
            end
            S_FETCH2, S_LDR1: begin
                c.mem_oe = 1'b1;
                c.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S_DECODE: begin
                c.ld_ben = 1'b1;
            end
            S_BR1: begin
                c.ld_pc    = 1'b1;
                c.pcmux    = PCMUX_ADDER;
                c.addr1mux = ADDR1_PC;
                c.addr2mux = ADDR2_OFF9;
            end
            S_ADD0, S_AND0, S_NOT0: begin
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.sr2_en   = 1'b1;
                if (s == S_AND0) begin
                    c.aluk = ALUK_AND;
                end else if (s == S_NOT0) begin
                    c.aluk = ALUK_NOT;
                end else begin
                    c.aluk = ALUK_ADD;
                end
            end
            S_LDR0: begin
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
                c.addr1mux    = ADDR1_BASER;
                c.addr2mux    = ADDR2_OFF6;
            end
            S_LDR2: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            default: begin
                c = CTRL_NONE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory wait-state counter: loaded when a memory access state is about to
// be entered, counts down once per cycle while the access is in progress.
module mem_wait_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [2:0] r_count;

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 3'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 3'd0)) begin
            r_count <= r_count - 3'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == 3'd0);

endmodule

// File: rtl/br_sequencer.sv
// SLC-3 instruction sequencer: fetch/decode/execute FSM for BR, ADD, AND,
// NOT, LDR and PAUSE. Control outputs are a Moore decode of the state,
// registered alongside it so they change only with the state.
module br_sequencer
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 32'd2   // memory read wait cycles, 1..7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic       SR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    // Counter holds remaining cycles after the current one, so load N-1
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 32'd1);

    state_t r_state;
    state_t w_next_state;
    state_t w_boundary;
    ctrl_t  r_ctrl;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;

    // Arm the counter in the cycle before each memory read state
    assign w_cnt_load = (r_state == S_FETCH1) || (r_state == S_LDR0);
    assign w_cnt_dec  = (r_state == S_FETCH2) || (r_state == S_LDR1);

    mem_wait_cnt u_wait_cnt (
        .i_clk      (Clk),
        .i_rst_n    (Reset),
        .i_load     (w_cnt_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Instruction boundary: Run is only honoured when the next fetch would start
    always_comb begin
        if (Run) begin
            w_boundary = S_FETCH1;
        end else begin
            w_boundary = S_HALTED;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HALTED: begin
                if (Run) begin
                    w_next_state = S_FETCH1;
                end else begin
                    w_next_state = S_HALTED;
                end
            end
            S_FETCH1: w_next_state = S_FETCH2;
            S_FETCH2: begin
                if (w_cnt_zero) begin
                    w_next_state = S_FETCH3;
                end else begin
                    w_next_state = S_FETCH2;
                end
            end
            S_FETCH3: w_next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_BR:    w_next_state = S_BR0;
                    OP_ADD:   w_next_state = S_ADD0;
                    OP_AND:   w_next_state = S_AND0;
                    OP_NOT:   w_next_state = S_NOT0;
                    OP_LDR:   w_next_state = S_LDR0;
                    OP_PAUSE: w_next_state = S_PAUSE0;
                    default:  w_next_state = w_boundary;
                endcase
            end
            S_BR0: begin
                if (BEN) begin
                    w_next_state = S_BR1;
                end else begin
                    w_next_state = w_boundary;
                end
            end
            S_BR1, S_ADD0, S_AND0, S_NOT0, S_LDR2: w_next_state = w_boundary;
            S_LDR0: w_next_state = S_LDR1;
            S_LDR1: begin
                if (w_cnt_zero) begin
                    w_next_state = S_LDR2;
                end else begin
                    w_next_state = S_LDR1;
                end
            end
            S_PAUSE0: begin
                if (Continue) begin
                    w_next_state = S_PAUSE1;
                end else begin
                    w_next_state = S_PAUSE0;
                end
            end
            S_PAUSE1: begin
                if (Continue) begin
                    w_next_state = S_PAUSE1;
                end else begin
                    w_next_state = w_boundary;
                end
            end
            default: w_next_state = S_HALTED;
        endcase
    end

    // State register with its control word decoded from the incoming state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_HALTED;
            r_ctrl  <= CTRL_NONE;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_decode(w_next_state);
        end
    end

    assign LD_MAR     = r_ctrl.ld_mar;
    assign LD_MDR     = r_ctrl.ld_mdr;
    assign LD_IR      = r_ctrl.ld_ir;
    assign LD_BEN     = r_ctrl.ld_ben;
    assign LD_CC      = r_ctrl.ld_cc;
    assign LD_REG     = r_ctrl.ld_reg;
    assign LD_PC      = r_ctrl.ld_pc;
    assign GatePC     = r_ctrl.gate_pc;
    assign GateMDR    = r_ctrl.gate_mdr;
    assign GateALU    = r_ctrl.gate_alu;
    assign GateMARMUX = r_ctrl.gate_marmux;
    assign PCMUX      = r_ctrl.pcmux;
    assign ADDR2MUX   = r_ctrl.addr2mux;
    assign ADDR1MUX   = r_ctrl.addr1mux;
    // Immediate select passes straight through in the ALU states
    assign SR2MUX     = r_ctrl.sr2_en & IR_5;
    assign ALUK       = r_ctrl.aluk;
    assign Mem_OE     = r_ctrl.mem_oe;
    // No store opcodes are sequenced here
    assign Mem_WE     = 1'b0;

endmodule

// File: doc/br_sequencer.md
BR_SEQUENCER -- requirements
Module: br_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: memory read wait cycles, legal range 1..7.
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports Run and Continue  input  1 each  level-sensitive start and resume requests.
REQ-005 SHALL have ports Opcode  input  4  IR[15:12]; IR_5  input  1  IR[5] immediate select; BEN  input  1  registered branch-enable from the NZP/BEN block.
REQ-006 SHALL have outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  output  1 each  register load strobes.
REQ-007 SHALL have outputs GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers, at most one high per cycle.
REQ-008 SHALL have outputs PCMUX, ADDR2MUX  output  2 each; ADDR1MUX, SR2MUX  output  1 each; ALUK  output  2  (00 ADD, 01 AND, 10 NOT, 11 PASS).
REQ-009 SHALL have outputs Mem_OE, Mem_WE  output  1 each  active-high memory enables.

Function
REQ-010 SHALL implement states HALTED, FETCH1, FETCH2, FETCH3, DECODE, BR0, BR1, ADD0, AND0, NOT0, LDR0, LDR1, LDR2, PAUSE0, PAUSE1.
REQ-011 SHALL leave HALTED for FETCH1 only when Run=1; otherwise remain in HALTED with all outputs 0.
REQ-012 FETCH1 SHALL assert GatePC, LD_MAR, LD_PC, PCMUX=00 (PC+1) for exactly one cycle.
REQ-013 FETCH2 SHALL assert Mem_OE and LD_MDR and remain for MEM_WAIT cycles, counted by a 3-bit counter loaded on entry; exit when the counter reaches 0.
REQ-014 FETCH3 SHALL assert GateMDR and LD_IR for one cycle, then go to DECODE.
REQ-015 DECODE SHALL assert LD_BEN only; next state by Opcode: 0000->BR0, 0001->ADD0, 0101->AND0, 1001->NOT0, 0110->LDR0, 1101->PAUSE0, any other->FETCH1.
REQ-016 LD_BEN SHALL be asserted only in DECODE; LD_CC SHALL be asserted only in ADD0, AND0, NOT0, LDR2.
REQ-017 BR0 SHALL assert no strobes; it SHALL sample BEN (valid one cycle after DECODE) and go to BR1 if BEN=1, else FETCH1.
REQ-018 BR1 SHALL assert LD_PC, PCMUX=10, ADDR1MUX=0 (PC), ADDR2MUX=10 (offset9), then go to FETCH1.
REQ-019 ADD0/AND0 SHALL assert GateALU, LD_REG, LD_CC, SR2MUX=IR_5, ALUK=00/01; NOT0 the same with ALUK=10; each then go to FETCH1.
REQ-020 LDR0 SHALL assert GateMARMUX, LD_MAR, ADDR1MUX=1 (BaseR), ADDR2MUX=01 (offset6); LDR1 SHALL behave as FETCH2 including MEM_WAIT; LDR2 SHALL assert GateMDR, LD_REG, LD_CC; then FETCH1.
REQ-021 PAUSE0 SHALL hold until Continue=1 then go to PAUSE1; PAUSE1 SHALL hold until Continue=0 then go to FETCH1 (one instruction per Continue pulse).
REQ-022 Run dropping to 0 SHALL return to HALTED only from FETCH1 entry (instruction boundary); in-flight instructions complete.
REQ-023 Outputs SHALL be a combinational decode of current state only (Moore), except SR2MUX which follows IR_5.
REQ-024 Mem_WE SHALL remain 0 in every state (no store opcodes in this block).

Reset
REQ-025 Reset=0 SHALL immediately force HALTED, wait counter 0, and all outputs 0, regardless of Clk.
REQ-026 Reset asserted mid-instruction (e.g. FETCH2 with counter nonzero) SHALL abandon it; after release the block SHALL wait in HALTED for Run.

Structure
REQ-027 State enum, ALUK codes, PCMUX/ADDR2MUX codes and opcode constants SHALL live in shared package slc3_pkg.
REQ-028 The wait counter SHALL be a sub-module mem_wait_cnt (load, decrement, zero flag); the FSM and output decode SHALL stay in br_sequencer.

Verification
REQ-029 Reset low during FETCH2 -> all outputs 0 same cycle; HALTED held after release with Run=0.
REQ-030 Run=1, Opcode=0001, IR_5=1, MEM_WAIT=2 -> sequence FETCH1, FETCH2 x2, FETCH3, DECODE, ADD0 with LD_CC=1, SR2MUX=1 only in ADD0.
REQ-031 Opcode=0000, BEN=1 -> BR1 asserts LD_PC with PCMUX=10; BEN=0 -> BR0 returns to FETCH1 with LD_PC never asserted.
REQ-032 Opcode=0110, MEM_WAIT=3 -> Mem_OE high exactly 3 cycles in LDR1; LD_CC high only in LDR2.
REQ-033 Opcode=1101, Continue held high 5 cycles -> exactly one pass through PAUSE1, next FETCH1 only after Continue=0.
REQ-034 Opcode=1111 -> DECODE returns directly to FETCH1; LD_REG, LD_CC never asserted.
